// File: rtl/apb_csr_master_if.sv
// apb_csr_master_if: APB link between the CSR initiator and the CSR register slave
// Signal names are seen from the master side.
// o_psel, o_penable, o_pwrite, o_paddr and o_pwdata are driven by the master.
// i_prdata, i_pready and i_pslverr are driven by the slave.
`timescale 1ns/1ps
interface apb_csr_master_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) ();
  logic              o_psel;
  logic              o_penable;
  logic              o_pwrite;
  logic [ADDR_W-1:0] o_paddr;
  logic [DATA_W-1:0] o_pwdata;
  logic [DATA_W-1:0] i_prdata;
  logic              i_pready;
  logic              i_pslverr;
  modport master (
    output o_psel, o_penable, o_pwrite, o_paddr, o_pwdata,
    input  i_prdata, i_pready, i_pslverr
  );
  modport slave (
    input  o_psel, o_penable, o_pwrite, o_paddr, o_pwdata,
    output i_prdata, i_pready, i_pslverr
  );
endinterface

// File: rtl/apb_csr_master.sv
// apb_csr_master: single-outstanding APB initiator driven by a request/done command port
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req, i_write, i_addr, i_wdata, o_ready : command accepted when i_req && o_ready
//   o_done, o_rdata, o_err : one-cycle completion pulse, last read data, transfer status
//   apb : APB master side (apb_csr_master_if.master)
// Optional macro APB_TIMEOUT_EN aborts ACCESS after TIMEOUT wait cycles with o_err=1.
`timescale 1ns/1ps
module apb_csr_master #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_req,
  input  logic                i_write,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic                o_ready,
  output logic                o_done,
  output logic [DATA_W-1:0]   o_rdata,
  output logic                o_err,
  apb_csr_master_if.master    apb
);
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;
  state_t            r_state, w_next;
  logic              r_write, r_done, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic              w_accept, w_complete, w_timeout;
  assign w_accept   = r_state == IDLE && i_req;
  assign w_complete = r_state == ACCESS && apb.i_pready;
`ifdef APB_TIMEOUT_EN
  logic [7:0] r_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_cnt <= '0;
    else if (r_state == SETUP) r_cnt <= '0;
    else if (r_state == ACCESS && !apb.i_pready) r_cnt <= r_cnt + 8'd1;
  end
  // A ready on the same edge wins over the abort.
  assign w_timeout = r_state == ACCESS && !apb.i_pready && r_cnt == 8'(TIMEOUT);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^8'(TIMEOUT);
  assign w_timeout = 1'b0;
`endif
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = i_req ? SETUP : IDLE;
      SETUP:   w_next = ACCESS;
      ACCESS:  w_next = (apb.i_pready || w_timeout) ? IDLE : ACCESS;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_complete || w_timeout;
      if (w_accept) begin
        r_write <= i_write;
        r_addr  <= i_addr;
        r_wdata <= i_write ? i_wdata : '0;
      end
      if (w_complete) r_err <= apb.i_pslverr;
      else if (w_timeout) r_err <= 1'b1;
      if (w_complete && !r_write && !apb.i_pslverr) r_rdata <= apb.i_prdata;
    end
  end
  // Bus controls decode straight from state so an asynchronous reset drops them at once.
  assign apb.o_psel    = r_state == SETUP || r_state == ACCESS;
  assign apb.o_penable = r_state == ACCESS;
  assign apb.o_pwrite  = r_write;
  assign apb.o_paddr   = r_addr;
  assign apb.o_pwdata  = r_wdata;
  assign o_ready = r_state == IDLE;
  assign o_done  = r_done;
  assign o_err   = r_err;
  assign o_rdata = r_rdata;
endmodule

// File: doc/apb_csr_master.md
# apb_csr_master

Single-outstanding APB initiator that drives the CSR register slave from a simple request/done command port. It sequences APB SETUP and ACCESS phases, stretches on `i_pready`, and returns read data plus `PSLVERR` status to the requester. Optionally, it aborts stalled transfers with a wait-state timeout. It is the initiator end of the CSR's APB link, used by the system-side controller and by the CSR bench.

## Interface

- `ADDR_W`, default 4: APB address width; matches the CSR address map.
- `DATA_W`, default 8: APB data width; matches the CSR register width.
- `TIMEOUT`, default 15: maximum number of ACCESS cycles with `i_pready` low before abort (range 1..255). Used only with `APB_TIMEOUT_EN`.

Ports:

- `i_clk` in 1: clock; all state changes on rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_req` in 1: command valid.
- `i_write` in 1: 1 = write, 0 = read; qualified by `i_req`.
- `i_addr` in `ADDR_W`: command address.
- `i_wdata` in `DATA_W`: command write data.
- `o_ready` out 1: command accepted on a rising edge with `i_req && o_ready`.
- `o_done` out 1: one-cycle completion pulse.
- `o_rdata` out `DATA_W`: last completed read data.
- `o_err` out 1: status of the completing transfer; valid with `o_done`.
- `o_psel`, `o_penable`, `o_pwrite` out 1: APB control.
- `o_paddr` out `ADDR_W`: APB address.
- `o_pwdata` out `DATA_W`: APB write data.
- `i_prdata` in `DATA_W`: APB read data.
- `i_pready` in 1: APB ready.
- `i_pslverr` in 1: APB slave error.

## Operation

- FSM states are IDLE, SETUP and ACCESS; the FSM is encoded in 2 bits, and the unused code returns to IDLE.
- **IDLE:**
  - `o_ready=1`, `o_psel=0`, `o_penable=0`.
  - When `i_req=1` at the edge, latch `i_write`, `i_addr` and `i_wdata`, then go to SETUP.
- **SETUP:**
  - `o_psel=1`, `o_penable=0`, `o_ready=0`.
  - `o_paddr` and `o_pwrite` come from the latched command.
  - `o_pwdata` is the latched wdata on a write and 0 on a read.
  - Unconditionally go to ACCESS.
- **ACCESS:**
  - `o_psel=1`, `o_penable=1`; address, write and data are held unchanged from SETUP.
  - With `i_pready=1` at the edge:
    - go to IDLE;
    - assert `o_done` for the next cycle;
    - `o_err <= i_pslverr`;
    - on a read with `i_pslverr=0`, `o_rdata <= i_prdata`.
  - With `i_pready=0`, stay in ACCESS (wait state).
- `o_rdata` is unchanged by writes and by errored reads.
- `o_err` holds its value until the next completion.
- `i_pslverr` and `i_prdata` are ignored unless `i_pready=1` in ACCESS.
- `i_req` is ignored outside IDLE. The latched command is immune to changes on `i_addr`, `i_wdata` and `i_write` after acceptance.
- `o_paddr`, `o_pwrite` and `o_pwdata` hold their last values in IDLE.

## Timing

- All outputs reset to 0 except `o_ready=1`; the state resets to IDLE.
- Reset is asynchronous. Asserting reset mid-transfer drops `o_psel` and `o_penable` immediately, and the transfer is lost with no `o_done`.
- Zero-wait transfer:
  - request sampled at edge E0;
  - SETUP during E0–E1;
  - ACCESS during E1–E2, with `i_pready` sampled at E2;
  - `o_done=1` during E2–E3.
- Each wait state adds one cycle.
- `o_ready=1` in the `o_done` cycle, so back-to-back commands run at one transfer per 3 cycles.
- `o_done` is never high for two consecutive cycles.

## Configuration

- Macro: `APB_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit wait counter clears on entry to ACCESS and increments on each ACCESS cycle with `i_pready=0`.
  - When the counter equals `TIMEOUT` and `i_pready=0`, go to IDLE, deassert `o_psel` and `o_penable`, and pulse `o_done` with `o_err=1`; `o_rdata` is unchanged.
  - If `i_pready=1` arrives on that same edge, it takes priority and the transfer completes normally.
- **Not defined:**
  - No counter is built; ACCESS waits indefinitely for `i_pready`.

## Test plan

- **Reset:** hold `i_rst_n=0` → all outputs 0 and `o_ready=1`. Then assert reset for 1 ns during ACCESS → `o_psel` and `o_penable` fall asynchronously, with no `o_done`.
- **Zero-wait write:** write addr 4'h3, data 8'hA5, with `i_pready` tied 1 → SETUP then ACCESS with `o_paddr=3`, `o_pwdata=A5`, `o_pwrite=1`; `o_done` at E2–E3 with `o_err=0`; `o_rdata` stays 0.
- **Wait-state read:** read addr 4'h7 with `i_pready` low for 3 ACCESS cycles and `i_prdata=8'h5C` → ACCESS lasts 4 cycles; `o_rdata=5C`, `o_done` for one cycle, address stable throughout.
- **Slave error:** read with `i_pslverr=1` and `i_prdata=8'hFF` at ready → `o_err=1` and `o_rdata` keeps its previous value 8'h5C.
- **Back-to-back:** `i_req` held high for writes 8'h01 then 8'h02 → second SETUP starts the cycle after the first `o_done`, giving 6 cycles total; `i_req` is ignored during SETUP and ACCESS.
- **Timeout (`APB_TIMEOUT_EN`, `TIMEOUT=15`):** `i_pready` held 0 → abort after 15 wait cycles with `o_done=1` and `o_err=1`. Without the macro, the master is still in ACCESS after 100 cycles.
